dmem_mmio: RTL and testbench

- Data-memory and peripheral block directly downstream of the core's memory stage.
- Consumes the memory-stage access (ALU address, rs2 store data, dm_ctrl, write enable) and returns load data, registered to line up with the WB pipeline register.
- Holds word-addressed data RAM, the LED output register, a synchronised switch input register and a free-running cycle counter on one memory map.

---
 rtl/mem_pkg.sv | 43 ++++
 rtl/dmem_mmio_if.sv | 22 ++
 rtl/load_align.sv | 29 ++
 rtl/dmem_mmio.sv | 138 +++++++++++++
 tb/tb_dmem_mmio.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared memory-stage definitions: access-type encodings, MMIO register offsets
// and small alignment/lane helpers used by the data memory and the load aligner.
package mem_pkg;

  typedef enum logic [2:0] {
    DM_B  = 3'b000,
    DM_H  = 3'b001,
    DM_W  = 3'b010,
    DM_BU = 3'b100,
    DM_HU = 3'b101
  } dm_ctrl_e;

  localparam logic [3:0] LED_OFS  = 4'h0;
  localparam logic [3:0] SW_OFS   = 4'h4;
  localparam logic [3:0] CYC_OFS  = 4'h8;
  localparam logic [3:0] CTRL_OFS = 4'hC;

  function automatic logic ctrlValid(input logic [2:0] ctrl);
    return ctrl inside {DM_B, DM_H, DM_W, DM_BU, DM_HU};
  endfunction

  function automatic logic isMisaligned(input logic [2:0] ctrl, input logic [1:0] ofs);
    logic result;
    case (ctrl)
      DM_H, DM_HU: result = ofs[0];
      DM_W:        result = (ofs != 2'b00);
      default:     result = 1'b0;
    endcase
    return result;
  endfunction

  // Byte lanes touched by a store; the size comes from ctrl[1:0] only.
  function automatic logic [3:0] laneMask(input logic [2:0] ctrl, input logic [1:0] ofs);
    logic [3:0] mask;
    case (ctrl[1:0])
      2'b00:   mask = 4'b0001 << ofs;
      2'b01:   mask = ofs[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// Memory-stage access bus between the core (master) and the data memory (slave).
interface dmem_mmio_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [2:0]  dm_ctrl;
  logic [31:0] rdata;
  logic        misalign;

  modport master (
    output addr, wdata, we, re, dm_ctrl,
    input  rdata, misalign
  );

  modport slave (
    input  addr, wdata, we, re, dm_ctrl,
    output rdata, misalign
  );

endinterface

// File: rtl/load_align.sv
// Combinational load aligner: selects the addressed byte/halfword from a captured
// word and sign- or zero-extends it. Shared with the instruction side.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_ofs,
  input  logic [2:0]  i_ctrl,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_ofs, 3'b000} +: 8];
    w_half = i_ofs[1] ? i_word[31:16] : i_word[15:0];
    o_data = '0;
    case (i_ctrl)
      DM_B:    o_data = {{24{w_byte[7]}}, w_byte};
      DM_BU:   o_data = {24'b0, w_byte};
      DM_H:    o_data = {{16{w_half[15]}}, w_half};
      DM_HU:   o_data = {16'b0, w_half};
      DM_W:    o_data = i_word;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus LED / switch / cycle-counter peripherals behind the memory stage.
// Optional counter feature: define DMEM_CYCLE_COUNTER_EN to build CYCLE and CTRL.
module dmem_mmio
  import mem_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
  input  logic           clk,
  input  logic           rst,
  dmem_mmio_if.slave     bus,
  input  logic [7:0]     i_switches,
  output logic [7:0]     o_leds
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_word;
  logic [1:0]    r_ofs;
  logic [2:0]    r_ctrl;
  logic          r_misalign;
  logic [7:0]    r_leds;
  logic [7:0]    r_swSync1;
  logic [7:0]    r_swSync;

  logic          w_isRam;
  logic          w_isMmio;
  logic [AW-1:0] w_idx;
  logic          w_misalign;
  logic          w_doWrite;
  logic          w_ledWr;
  logic [3:0]    w_laneMask;
  logic [31:0]   w_wLanes;
  logic [31:0]   w_rdWord;
  logic [31:0]   w_cycle;
  logic [31:0]   w_rdata;

  assign w_isRam    = (bus.addr[31:AW+2] == '0);
  assign w_isMmio   = (bus.addr[31:4] == MMIO_BASE[31:4]);
  assign w_idx      = bus.addr[AW+1:2];
  assign w_misalign = (bus.we | bus.re) &
                      (isMisaligned(bus.dm_ctrl, bus.addr[1:0]) |
                       (bus.we & ~ctrlValid(bus.dm_ctrl)));
  assign w_doWrite  = bus.we & ~w_misalign;
  assign w_ledWr    = w_doWrite & w_isMmio & (bus.addr[3:0] == LED_OFS);
  assign w_laneMask = laneMask(bus.dm_ctrl, bus.addr[1:0]);

  // Replicate the store data so every lane already holds the right bytes.
  always_comb begin
    w_wLanes = bus.wdata;
    case (bus.dm_ctrl[1:0])
      2'b00:   w_wLanes = {4{bus.wdata[7:0]}};
      2'b01:   w_wLanes = {2{bus.wdata[15:0]}};
      default: w_wLanes = bus.wdata;
    endcase
  end

  always_comb begin
    w_rdWord = '0;
    if (w_isRam) begin
      w_rdWord = r_mem[w_idx];
    end else if (w_isMmio) begin
      case ({bus.addr[3:2], 2'b00})
        LED_OFS: w_rdWord = {24'b0, r_leds};
        SW_OFS:  w_rdWord = {24'b0, r_swSync};
        CYC_OFS: w_rdWord = w_cycle;
        default: w_rdWord = '0;
      endcase
    end
  end

  // RAM is never reset, so a store in the reset cycle still lands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_doWrite && w_isRam && w_laneMask[i]) begin
        r_mem[w_idx][8*i +: 8] <= w_wLanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word     <= '0;
      r_ofs      <= '0;
      r_ctrl     <= DM_W;
      r_misalign <= 1'b0;
      r_leds     <= '0;
      r_swSync1  <= '0;
      r_swSync   <= '0;
    end else begin
      r_misalign <= w_misalign;
      r_swSync1  <= i_switches;
      r_swSync   <= r_swSync1;
      if (w_ledWr) begin
        r_leds <= bus.wdata[7:0];
      end
      if (w_misalign) begin
        r_word <= '0;
      end else if (bus.re) begin
        r_word <= w_rdWord;
        r_ofs  <= bus.addr[1:0];
        r_ctrl <= bus.dm_ctrl;
      end
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] r_cycle;
  logic        w_ctrlClr;

  assign w_ctrlClr = w_doWrite & w_isMmio & (bus.addr[3:0] == CTRL_OFS) & bus.wdata[0];

  always_ff @(posedge clk) begin
    if (rst || w_ctrlClr) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  assign w_cycle = r_cycle;
`else
  assign w_cycle = '0;
`endif

  load_align u_loadAlign (
    .i_word (r_word),
    .i_ofs  (r_ofs),
    .i_ctrl (r_ctrl),
    .o_data (w_rdata)
  );

  assign bus.rdata    = w_rdata;
  assign bus.misalign = r_misalign;
  assign o_leds       = r_leds;

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: byte-array reference model, per-cycle
// compare of rdata/misalign/leds, directed literal pins and a random phase.
module tb_dmem_mmio;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] switches;
  logic [7:0] leds;

  dmem_mmio_if bus ();

  dmem_mmio #(.DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .i_switches (switches),
    .o_leds     (leds)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFails = 0;

  // Reference model state: memory as plain bytes, peripherals as plain values.
  logic [7:0]  mB [DEPTH*4];
  logic [7:0]  mLeds;
  logic [7:0]  mSync1;
  logic [7:0]  mSwSync;
  logic [31:0] mCnt;
  logic [31:0] expRdata;
  logic        expMis;
  bit          modelValid = 1'b0;

  function automatic logic [31:0] modelWord(input logic [31:0] a);
    int base;
    if (a < DEPTH*4) begin
      base = int'(a) & ~3;
      return {mB[base+3], mB[base+2], mB[base+1], mB[base]};
    end
    if (a >= BASE && a < BASE + 16) begin
      case ((a - BASE) >> 2)
        0: return {24'b0, mLeds};
        1: return {24'b0, mSwSync};
`ifdef DMEM_CYCLE_COUNTER_EN
        2: return mCnt;
`endif
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] ofs,
                                          input logic [2:0] c);
    logic [31:0] v;
    v = word >> (8 * ofs);
    case (c)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b100:  return {24'b0, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b101:  return {16'b0, v[15:0]};
      3'b010:  return word;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [31:0] a;
    logic [31:0] rd;
    logic [2:0]  c;
    int          size;
    bit          valid;
    bit          mis;
    bit          clr;
    a     = bus.addr;
    c     = bus.dm_ctrl;
    valid = c inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    size  = (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
    mis   = (bus.we || bus.re) &&
            ((valid && (a % size) != 0) || (bus.we && !valid));
    if (mis) rd = 32'h0;
    else if (bus.re) rd = extract(modelWord(a), a[1:0], c);
    else rd = expRdata;
    clr = 1'b0;
    if (bus.we && !mis) begin
      if (a < DEPTH*4) begin
        for (int i = 0; i < size; i++) mB[int'(a) + i] = bus.wdata[8*i +: 8];
      end
      if (a == BASE) mLeds = bus.wdata[7:0];
      if (a == BASE + 12 && bus.wdata[0]) clr = 1'b1;
    end
    mSwSync  = mSync1;
    mSync1   = switches;
    mCnt     = clr ? 32'h0 : mCnt + 32'd1;
    expRdata = rd;
    expMis   = mis;
    if (rst) begin
      expRdata = 32'h0;
      expMis   = 1'b0;
      mLeds    = 8'h0;
      mCnt     = 32'h0;
      mSync1   = 8'h0;
      mSwSync  = 8'h0;
    end
    modelValid = modelValid | rst;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("rdata", bus.rdata, expRdata);
      checkOutput("misalign", {31'b0, bus.misalign}, {31'b0, expMis});
      checkOutput("leds", {24'b0, leds}, {24'b0, mLeds});
    end
  end

  task automatic applyStimulus(input logic r, input logic w, input logic rd,
                               input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst         = r;
    bus.we      = w;
    bus.re      = rd;
    bus.dm_ctrl = c;
    bus.addr    = a;
    bus.wdata   = d;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
  endtask

  task automatic pinNow(input string name, input logic [31:0] act, input logic [31:0] mdl,
                        input logic [31:0] lit);
    checkOutput(name, act, lit);
    checkOutput({name, "_model"}, mdl, lit);
  endtask

  task automatic doLoad(input logic [2:0] c, input logic [31:0] a, input string name,
                        input logic [31:0] lit);
    applyStimulus(1'b0, 1'b0, 1'b1, c, a, 32'h0);
    idle();
    @(negedge clk);
    pinNow(name, bus.rdata, expRdata, lit);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0]  valids [5];
    logic [2:0]  bad [3];
    logic [31:0] a;
    logic [2:0]  c;
    logic        w;
    logic        r;
    int          k;
    int          size;
    valids = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    bad    = '{3'b011, 3'b110, 3'b111};

    rst = 1'b1; bus.we = 1'b0; bus.re = 1'b0; bus.dm_ctrl = 3'b010;
    bus.addr = 32'h0; bus.wdata = 32'h0; switches = 8'h00;
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    idle();
    @(negedge clk);
    pinNow("reset_rdata", bus.rdata, expRdata, 32'h0);
    pinNow("reset_leds", {24'b0, leds}, {24'b0, mLeds}, 32'h0);
    pinNow("reset_mis", {31'b0, bus.misalign}, {31'b0, expMis}, 32'h0);

    for (int i = 0; i < 32; i++) applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, i * 4, $urandom);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, (DEPTH - 1) * 4, $urandom);

    applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'hDEAD_BEEF);
    doLoad(3'b010, 32'h10, "lw_10", 32'hDEAD_BEEF);
    doLoad(3'b000, 32'h13, "lb_13", 32'hFFFF_FFDE);
    doLoad(3'b100, 32'h13, "lbu_13", 32'h0000_00DE);
    doLoad(3'b001, 32'h12, "lh_12", 32'hFFFF_DEAD);

    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 32'h11, 32'h0000_005A);
    doLoad(3'b010, 32'h10, "lw_after_sb", 32'hDEAD_5AEF);

    doLoad(3'b010, 32'h12, "lw_misal_rdata", 32'h0);
    pinNow("lw_misal_pulse", {31'b0, bus.misalign}, {31'b0, expMis}, 32'h1);
    idle();
    @(negedge clk);
    pinNow("misal_one_cycle", {31'b0, bus.misalign}, {31'b0, expMis}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b001, 32'h13, 32'h0000_FFFF);
    idle();
    @(negedge clk);
    pinNow("sh_misal_pulse", {31'b0, bus.misalign}, {31'b0, expMis}, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
    idle();
    @(negedge clk);
    pinNow("bad_ctrl_pulse", {31'b0, bus.misalign}, {31'b0, expMis}, 32'h1);
    doLoad(3'b010, 32'h10, "ram_unchanged", 32'hDEAD_5AEF);

    applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, (DEPTH - 1) * 4, 32'h1122_3344);
    doLoad(3'b010, (DEPTH - 1) * 4, "lw_last_word", 32'h1122_3344);
    doLoad(3'b010, DEPTH * 4, "lw_past_ram", 32'h0);

    applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, BASE, 32'h1234_56A5);
    idle();
    @(negedge clk);
    pinNow("leds_a5", {24'b0, leds}, {24'b0, mLeds}, 32'hA5);
    idle();
    switches = 8'h3C;
    idle();
    doLoad(3'b010, BASE + 4, "lw_switch", 32'h0000_003C);

`ifdef DMEM_CYCLE_COUNTER_EN
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, BASE + 12, 32'h1);
    for (int i = 0; i < 5; i++) idle();
    doLoad(3'b010, BASE + 8, "lw_cycle", 32'h5);
`else
    doLoad(3'b010, BASE + 8, "lw_cycle_off", 32'h0);
`endif

    applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'hCAFE_F00D);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h24, 32'h0BAD_C0DE);
    @(negedge clk);
    pinNow("lw_before_rst", bus.rdata, expRdata, 32'hCAFE_F00D);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, BASE, 32'h0000_00FF);
    idle();
    @(negedge clk);
    pinNow("rst_rdata", bus.rdata, expRdata, 32'h0);
    pinNow("rst_leds", {24'b0, leds}, {24'b0, mLeds}, 32'h0);
    pinNow("rst_mis", {31'b0, bus.misalign}, {31'b0, expMis}, 32'h0);
    doLoad(3'b010, 32'h20, "ram_kept", 32'hCAFE_F00D);
    doLoad(3'b010, 32'h24, "ram_rst_store", 32'h0BAD_C0DE);

    for (int n = 0; n < 1500; n++) begin
      c = valids[$urandom_range(0, 4)];
      k = $urandom_range(0, 9);
      w = (k >= 4 && k <= 6);
      r = (k <= 3);
      if (w && $urandom_range(0, 9) == 0) c = bad[$urandom_range(0, 2)];
      size = (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
      k = $urandom_range(0, 9);
      if (k <= 5) a = $urandom_range(0, 31) * 4 + $urandom_range(0, 3);
      else if (k == 6) a = (DEPTH - 1) * 4 + $urandom_range(0, 3);
      else if (k == 7) a = DEPTH * 4 + $urandom_range(0, 255);
      else if (k == 8) a = BASE + $urandom_range(0, 15);
      else a = $urandom | 32'h0010_0000;
      if ($urandom_range(0, 3) != 0) a = a & ~(size - 1);
      if ($urandom_range(0, 15) == 0) switches = 8'($urandom);
      applyStimulus($urandom_range(0, 199) == 0, w, r, c, a, $urandom);
    end
    idle();
    idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule
